multicycle_shift_sequencer: RTL and testbench

//  Sequences a variable-amount shift of an N-bit word over several cycles.

---
 rtl/multicycle_shift_sequencer.sv | 120 ++++++++++++
 tb/tb_multicycle_shift_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_shift_sequencer.sv
// Multi-cycle shifter: applies at most STEP bits of shift per cycle until the requested amount is consumed.
// Optional feature macro: ARITH_SHIFT_EN (arithmetic right shifts selected by up_arith).
module multicycle_shift_sequencer #(
  parameter int N    = 8,
  parameter int STEP = 1,
  localparam int AW  = $clog2(N) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          up_valid,
  output logic          up_ready,
  input  logic [N-1:0]  up_data,
  input  logic [AW-1:0] up_amount,
  input  logic          up_dir,
  input  logic          up_arith,
  output logic          down_valid,
  input  logic          down_ready,
  output logic [N-1:0]  down_data,
  output logic          busy
);

  localparam logic [AW-1:0] N_W    = AW'(N);
  localparam logic [AW-1:0] STEP_W = AW'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [N-1:0]   r_data;
  logic [N-1:0]   r_out;
  logic [AW-1:0]  r_rem;
  logic           r_dir;
  logic [AW-1:0]  w_amt_clamp;
  logic [AW-1:0]  w_k;
  logic [AW-1:0]  w_rem_next;
  logic [N-1:0]   w_shifted;

`ifdef ARITH_SHIFT_EN
  logic           r_arith;
`else
  logic           w_unused_arith;
  assign w_unused_arith = up_arith;
`endif

  assign w_amt_clamp = (up_amount > N_W) ? N_W : up_amount;
  assign w_k         = (r_rem > STEP_W) ? STEP_W : r_rem;
  assign w_rem_next  = r_rem - w_k;

  // One shift stage; the arithmetic form keeps the sign bit so repeated stages keep filling with it.
  always_comb begin
    if (r_dir) begin
      w_shifted = r_data << w_k;
    end
`ifdef ARITH_SHIFT_EN
    else if (r_arith) begin
      w_shifted = N'($signed(r_data) >>> w_k);
    end
`endif
    else begin
      w_shifted = r_data >> w_k;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (up_valid) w_next_state = (w_amt_clamp == '0) ? S_DONE : S_SHIFT;
      S_SHIFT: if (w_rem_next == '0) w_next_state = S_DONE;
      S_DONE:  if (down_ready) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_out   <= '0;
      r_rem   <= '0;
      r_dir   <= 1'b0;
`ifdef ARITH_SHIFT_EN
      r_arith <= 1'b0;
`endif
    end else begin
      r_state <= w_next_state;
      case (r_state)
        S_IDLE: begin
          if (up_valid) begin
            r_data <= up_data;
            r_rem  <= w_amt_clamp;
            r_dir  <= up_dir;
`ifdef ARITH_SHIFT_EN
            r_arith <= up_arith;
`endif
            if (w_amt_clamp == '0) r_out <= up_data;
          end
        end
        S_SHIFT: begin
          r_data <= w_shifted;
          r_rem  <= w_rem_next;
          // The result register only changes on entry to DONE so it holds during SHIFT and IDLE.
          if (w_rem_next == '0) r_out <= w_shifted;
        end
        default: ;
      endcase
    end
  end

  assign up_ready   = (r_state == S_IDLE);
  assign busy       = (r_state != S_IDLE);
  assign down_valid = (r_state == S_DONE);
  assign down_data  = r_out;

endmodule

// File: tb/tb_multicycle_shift_sequencer.sv
// Self-checking bench for multicycle_shift_sequencer (N=8, STEP=2): directed literal cases plus
// randomized traffic compared cycle by cycle against a transaction-level model.
module tb_multicycle_shift_sequencer;

  localparam int N    = 8;
  localparam int STEP = 2;
  localparam int AW   = $clog2(N) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          up_valid;
  logic          up_ready;
  logic [N-1:0]  up_data;
  logic [AW-1:0] up_amount;
  logic          up_dir;
  logic          up_arith;
  logic          down_valid;
  logic          down_ready;
  logic [N-1:0]  down_data;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  multicycle_shift_sequencer #(.N(N), .STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amount  (up_amount),
    .up_dir     (up_dir),
    .up_arith   (up_arith),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int clamp_amt(input logic [AW-1:0] a);
    return (int'(a) > N) ? N : int'(a);
  endfunction

  // Whole-word result computed bit by bit from the source position of each output bit.
  function automatic logic [N-1:0] ref_shift(input logic [N-1:0] d, input int a,
                                             input logic dir, input logic arith);
    logic [N-1:0] r;
    logic         fill;
`ifdef ARITH_SHIFT_EN
    fill = (!dir && arith) ? d[N-1] : 1'b0;
`else
    fill = 1'b0 & arith;
`endif
    for (int i = 0; i < N; i++) begin
      int src;
      src  = dir ? (i - a) : (i + a);
      r[i] = (src >= 0 && src < N) ? d[src] : (dir ? 1'b0 : fill);
    end
    return r;
  endfunction

  // Transaction-level model: idle / counting edges until done / done.
  logic         m_live = 1'b0;
  logic         m_busy, m_done;
  int           m_left;
  logic [N-1:0] m_res, m_out;

  always @(posedge clk) begin
    if (rst) begin
      m_live <= 1'b1;
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_out  <= '0;
    end else if (m_live) begin
      if (m_done) begin
        if (down_ready) begin
          m_done <= 1'b0;
          m_busy <= 1'b0;
        end
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_done <= 1'b1;
          m_out  <= m_res;
        end
        m_left <= m_left - 1;
      end else if (up_valid) begin
        m_busy <= 1'b1;
        m_res  <= ref_shift(up_data, clamp_amt(up_amount), up_dir, up_arith);
        m_left <= (clamp_amt(up_amount) + STEP - 1) / STEP;
        if (clamp_amt(up_amount) == 0) begin
          m_done <= 1'b1;
          m_out  <= up_data;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("mdl_up_ready",   up_ready,   !m_busy);
      check("mdl_busy",       busy,       m_busy);
      check("mdl_down_valid", down_valid, m_done);
      check("mdl_down_data",  down_data,  m_out);
    end
  end

  task automatic run_op(input logic [N-1:0] d, input logic [AW-1:0] amt, input logic dir,
                        input logic arith, input logic [N-1:0] exp_d, input int exp_lat,
                        input int stall);
    int n;
    n = 0;
    while (!up_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("op_ready_before", up_ready, 1);
    up_valid   = 1'b1;
    up_data    = d;
    up_amount  = amt;
    up_dir     = dir;
    up_arith   = arith;
    down_ready = 1'b0;
    @(negedge clk);
    n = 1;
    while (!down_valid && n < 50) begin
      up_valid  = 1'($urandom);
      up_data   = N'($urandom);
      up_amount = AW'($urandom);
      up_dir    = 1'($urandom);
      up_arith  = 1'($urandom);
      down_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    down_ready = 1'b0;
    check("op_latency", n, exp_lat);
    check("op_data", down_data, exp_d);
    repeat (stall) begin
      @(negedge clk);
      check("stall_valid", down_valid, 1);
      check("stall_data",  down_data,  exp_d);
      check("stall_up_ready", up_ready, 0);
    end
    up_valid   = 1'b1;
    down_ready = 1'b1;
    @(negedge clk);
    down_ready = 1'b0;
    up_valid   = 1'b0;
    check("release_up_ready",   up_ready,   1);
    check("release_down_valid", down_valid, 0);
  endtask

  initial begin
    rst        = 1'b1;
    up_valid   = 1'b0;
    up_data    = '0;
    up_amount  = '0;
    up_dir     = 1'b0;
    up_arith   = 1'b0;
    down_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_up_ready",   up_ready,   1);
    check("rst_down_valid", down_valid, 0);
    check("rst_busy",       busy,       0);
    check("rst_down_data",  down_data,  0);
    rst = 1'b0;

    run_op(8'hB6, 4'd5,  1'b0, 1'b0, 8'h05, 4, 0);
    run_op(8'hB6, 4'd3,  1'b1, 1'b0, 8'hB0, 3, 0);
    run_op(8'hB6, 4'd0,  1'b0, 1'b0, 8'hB6, 1, 0);
    run_op(8'hB6, 4'd12, 1'b0, 1'b0, 8'h00, 5, 0);
    run_op(8'h5A, 4'd1,  1'b1, 1'b0, 8'hB4, 2, 5);
`ifdef ARITH_SHIFT_EN
    run_op(8'hB6, 4'd3,  1'b0, 1'b1, 8'hF6, 3, 0);
    run_op(8'hB6, 4'd15, 1'b0, 1'b1, 8'hFF, 5, 0);
`else
    run_op(8'hB6, 4'd3,  1'b0, 1'b1, 8'h16, 3, 0);
`endif
    run_op(8'hB6, 4'd3,  1'b0, 1'b0, 8'h16, 3, 0);
    run_op(8'hB6, 4'd3,  1'b1, 1'b1, 8'hB0, 3, 0);

    // Abort mid-SHIFT, then a fresh request must still complete.
    up_valid  = 1'b1;
    up_data   = 8'hFF;
    up_amount = 4'd8;
    up_dir    = 1'b1;
    @(negedge clk);
    up_valid = 1'b0;
    @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_up_ready",   up_ready,   1);
    check("abort_down_valid", down_valid, 0);
    check("abort_down_data",  down_data,  0);
    check("abort_busy",       busy,       0);
    run_op(8'h3C, 4'd2, 1'b1, 1'b0, 8'hF0, 2, 0);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 199) == 0);
      up_valid   = 1'($urandom);
      up_data    = N'($urandom);
      up_amount  = AW'($urandom);
      up_dir     = 1'($urandom);
      up_arith   = 1'($urandom);
      down_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst        = 1'b0;
    up_valid   = 1'b0;
    down_ready = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
